pll_recfg_seq: RTL
==================

// Module: pll_recfg_seq
// PURPOSE
// - Sequences a runtime reconfiguration of the SDRAM clock PLL through the Avalon-MM mgmt port of pll_cfg.
// - Writes mode, M, K, N, C0, charge-pump and bandwidth, then starts the update, pulses PLL reset and waits for lock.
// - Sits between the speed-step selector (keyboard/auto-step logic) and pll_cfg; runs on the 50 MHz mgmt clock.
// PARAMETERS
// - GAP_CYCLES    8        idle cycles between consecutive mgmt writes (>=1)
// - RST_CYCLES    8        cycles pll_reset is held high after the start write
// - LOCK_TIMEOUT  5000000  cycles to wait for lock before flagging error (100 ms @ 50 MHz)
// - N_VAL         'h10000  N counter word (bypass)
// - CP_VAL        1        charge-pump word
// - BW_VAL        7        bandwidth word
// PORTS
// - clk              in   1   mgmt clock (CLK_50M)
// - rst_n            in   1   synchronous active-low reset
// - start            in   1   1-cycle request; m_val/k_val/c_val sampled on the same edge
// - m_val            in   32  M counter word
// - k_val            in   32  fractional K word
// - c_val            in   32  C0 counter word
// - pll_locked       in   1   PLL lock, already synchronised to clk
// - mgmt_waitrequest in   1   Avalon-MM waitrequest from pll_cfg
// - mgmt_write       out  1   Avalon-MM write strobe
// - mgmt_address     out  6   Avalon-MM register address
// - mgmt_writedata   out  32  Avalon-MM write data
// - pll_reset        out  1   PLL reset, active high
// - busy             out  1   high from accepted start until done
// - done             out  1   1-cycle pulse at end of sequence (success or timeout)
// - error            out  1   sticky lock-timeout flag, cleared on next accepted start
// BEHAVIOUR
// - Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, pll_reset=0, busy=0, done=0, error=0; state IDLE.
// - States: IDLE -> WRITE -> GAP -> (WRITE ... ) -> RST -> LOCK -> IDLE.
// - IDLE: start=1 latches m/k/c, clears error, sets busy next cycle, step=0, goes to WRITE.
// - start while busy is ignored; no queueing, latched values unchanged.
// - Write table (step: addr, data): 0: 0,0 | 1: 4,M | 2: 7,K | 3: 3,N_VAL | 4: 5,C0 | 5: 9,CP_VAL | 6: 8,BW_VAL | 7: 2,0 (start).
// - WRITE: mgmt_write=1 with address/data stable; the write completes on the first edge where mgmt_write=1 and
//   mgmt_waitrequest=0; mgmt_write drops the next cycle. Address/data must not change while waitrequest=1.
// - GAP: GAP_CYCLES idle cycles; then step+1 -> WRITE, or after step 7 -> RST.
// - RST: pll_reset=1 for exactly RST_CYCLES cycles, then 0 and -> LOCK with timeout counter cleared.
// - LOCK: pll_locked=1 -> done pulse, busy=0, -> IDLE. Counter reaching LOCK_TIMEOUT-1 -> error=1, done pulse, -> IDLE.
// - Minimum latency start->done with waitrequest=0 and immediate lock: 8*(1+GAP_CYCLES)+RST_CYCLES+2 cycles.
// - done and busy fall are coincident in the same cycle; done never asserts outside that cycle.
// - rst_n=0 mid-sequence: all outputs to reset values on the next edge, including pll_reset=0 and mgmt_write=0.
// - start asserted in the same cycle as done: ignored (busy still 1).
// - Lock counter width: $clog2(LOCK_TIMEOUT+1); gap/reset counters sized from their parameters; no wrap possible.
// STRUCTURE
// - Shared package pll_recfg_pkg: state enum (IDLE, WRITE, GAP, RST, LOCK); register address constants
//   REG_MODE=0, REG_START=2, REG_N=3, REG_M=4, REG_C0=5, REG_BW=8, REG_CP=9, REG_K=7.
// - Single module; write table is a combinational case on step[2:0]. No sub-module.
// TESTING
// - start, m='h00808, k='hB33332DD, c='h20302, waitrequest=0, lock after 10 cycles -> 8 writes in table order
//   with exact addr/data, pll_reset high 8 cycles, one done pulse, error=0.
// - waitrequest held high 5 cycles during step 2 -> mgmt_write stays 1, addr=7/data=K stable all 5 cycles,
//   single completed write, sequence resumes.
// - pll_locked never rises -> done pulse exactly LOCK_TIMEOUT cycles after pll_reset falls, error=1 sticky;
//   next start clears error.
// - second start pulse during step 4 -> ignored; write count still 8, latched M unchanged.
// - rst_n=0 while pll_reset=1 -> next edge pll_reset=0, busy=0, mgmt_write=0; start afterwards runs full sequence.
// - start on the done cycle -> no new sequence; start one cycle later -> accepted.

Source files
------------

// File: rtl/pll_recfg_pkg.sv
// Shared definitions for the SDRAM PLL reconfiguration sequencer:
// sequencer states and pll_cfg mgmt register map.
package pll_recfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP,
        RST,
        LOCK
    } state_t;

    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_N     = 6'd3;
    localparam logic [5:0] REG_M     = 6'd4;
    localparam logic [5:0] REG_C0    = 6'd5;
    localparam logic [5:0] REG_K     = 6'd7;
    localparam logic [5:0] REG_BW    = 6'd8;
    localparam logic [5:0] REG_CP    = 6'd9;

    localparam int N_STEPS = 8;

endpackage

// File: rtl/pll_recfg_seq.sv
// Runtime reconfiguration sequencer for the SDRAM clock PLL: eight mgmt
// writes into pll_cfg, a PLL reset pulse, then a bounded wait for lock.
module pll_recfg_seq
    import pll_recfg_pkg::*;
#(
    parameter int          GAP_CYCLES   = 8,
    parameter int          RST_CYCLES   = 8,
    parameter int          LOCK_TIMEOUT = 5000000,
    parameter logic [31:0] N_VAL        = 32'h10000,
    parameter logic [31:0] CP_VAL       = 32'd1,
    parameter logic [31:0] BW_VAL       = 32'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] m_val,
    input  logic [31:0] k_val,
    input  logic [31:0] c_val,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        pll_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [31:0]       m_lat_q, m_lat_d;
    logic [31:0]       k_lat_q, k_lat_d;
    logic [31:0]       c_lat_q, c_lat_d;
    logic              write_q, write_d;
    logic              pll_reset_q, pll_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            gap_cnt_q   <= '0;
            rst_cnt_q   <= '0;
            lock_cnt_q  <= '0;
            write_q     <= 1'b0;
            pll_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            gap_cnt_q   <= gap_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            write_q     <= write_d;
            pll_reset_q <= pll_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Request words are only loaded on an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        m_lat_q <= m_lat_d;
        k_lat_q <= k_lat_d;
        c_lat_q <= c_lat_d;
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        gap_cnt_d   = gap_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        m_lat_d     = m_lat_q;
        k_lat_d     = k_lat_q;
        c_lat_d     = c_lat_q;
        write_d     = write_q;
        pll_reset_d = pll_reset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;

        // busy spans the done cycle and drops together with done.
        if (done_q)
            busy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    m_lat_d = m_val;
                    k_lat_d = k_val;
                    c_lat_d = c_val;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    step_d  = 3'd0;
                    write_d = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!mgmt_waitrequest) begin
                    write_d   = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (step_q == 3'(N_STEPS - 1)) begin
                        pll_reset_d = 1'b1;
                        rst_cnt_d   = '0;
                        state_d     = RST;
                    end else begin
                        step_d  = step_q + 3'd1;
                        write_d = 1'b1;
                        state_d = WRITE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    pll_reset_d = 1'b0;
                    lock_cnt_d  = '0;
                    state_d     = LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            LOCK: begin
                if (pll_locked) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/data follow the step register, so they hold still through waitrequest.
    always_comb begin
        mgmt_address   = REG_MODE;
        mgmt_writedata = 32'd0;
        case (step_q)
            3'd0: begin mgmt_address = REG_MODE;  mgmt_writedata = 32'd0;   end
            3'd1: begin mgmt_address = REG_M;     mgmt_writedata = m_lat_q; end
            3'd2: begin mgmt_address = REG_K;     mgmt_writedata = k_lat_q; end
            3'd3: begin mgmt_address = REG_N;     mgmt_writedata = N_VAL;   end
            3'd4: begin mgmt_address = REG_C0;    mgmt_writedata = c_lat_q; end
            3'd5: begin mgmt_address = REG_CP;    mgmt_writedata = CP_VAL;  end
            3'd6: begin mgmt_address = REG_BW;    mgmt_writedata = BW_VAL;  end
            3'd7: begin mgmt_address = REG_START; mgmt_writedata = 32'd0;   end
            default: begin mgmt_address = REG_MODE; mgmt_writedata = 32'd0; end
        endcase
    end

    assign mgmt_write = write_q;
    assign pll_reset  = pll_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
